// File: rtl/stack_op_sequencer.sv
// Program sequencer for the stack ALU: holds a small {opcode, operand} program
// and issues it one accepted handshake at a time until halt, end or overflow.
module stack_op_sequencer #(
  parameter int N     = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [N+2:0]  load_data,
  input  logic          start,
  output logic [N-1:0]  stk_in,
  output logic [2:0]    stk_opcode,
  output logic          stk_valid,
  input  logic          stk_ready,
  input  logic          stk_overflow,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc,
  output logic [AW:0]   issued
);

  localparam int unsigned WW = N + 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [2:0]    OP_HALT = 3'b001;
  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

  logic [WW-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   issued_q, issued_d;
  logic [2:0]    op_hold_q;
  logic [N-1:0]  in_hold_q;

  logic [WW-1:0] word;
  logic [2:0]    cur_op;
  logic [N-1:0]  cur_arg;
  logic          run;
  logic          is_halt;
  logic          hs;

  assign word    = mem[pc_q];
  assign cur_op  = word[N+2:N];
  assign cur_arg = word[N-1:0];
  assign run     = (state_q == S_RUN);
  assign is_halt = (cur_op == OP_HALT);
  assign hs      = run && !is_halt && stk_ready;

  // Program store: written only while not executing, never reset.
  always_ff @(posedge clk) begin
    if (load_en && (state_q != S_RUN)) begin
      mem[load_addr] <= load_data;
    end
  end

  // State, program counter and issue count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      issued_q <= issued_d;
    end
  end

  // Last driven instruction, held on the stack bus while not running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_hold_q <= '0;
      in_hold_q <= '0;
    end else if (run) begin
      op_hold_q <= cur_op;
      in_hold_q <= cur_arg;
    end
  end

  // Next-state logic; overflow wins over halt and over a same-cycle handshake.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    issued_d = issued_q;
    case (state_q)
      S_RUN: begin
        if (hs) begin
          issued_d = issued_q + (AW+1)'(1);
        end
        if (stk_overflow) begin
          state_d = S_ERR;
          if (hs && (pc_q != LAST_PC)) begin
            pc_d = pc_q + AW'(1);
          end
        end else if (is_halt) begin
          state_d = S_DONE;
        end else if (hs) begin
          if (pc_q == LAST_PC) begin
            state_d = S_DONE;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end
      default: begin
        if (start) begin
          state_d  = S_RUN;
          pc_d     = '0;
          issued_d = '0;
        end
      end
    endcase
  end

  // Stack bus follows the program word at pc while running.
  always_comb begin
    stk_opcode = run ? cur_op  : op_hold_q;
    stk_in     = run ? cur_arg : in_hold_q;
    stk_valid  = run && !is_halt;
  end

  assign busy   = run;
  assign done   = (state_q == S_DONE);
  assign err    = (state_q == S_ERR);
  assign pc     = pc_q;
  assign issued = issued_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Randomized bench for stack_op_sequencer against a transaction-level model:
// the expected issue stream is derived from the program contents directly.
module tb_stack_op_sequencer;

  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [N+2:0]  load_data;
  logic          start;
  logic [N-1:0]  stk_in;
  logic [2:0]    stk_opcode;
  logic          stk_valid;
  logic          stk_ready;
  logic          stk_overflow;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] pc;
  logic [AW:0]   issued;

  logic [N+2:0]  prog [DEPTH];
  int n_cmp = 0;
  int n_bad = 0;

  stack_op_sequencer #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stk_in(stk_in),
    .stk_opcode(stk_opcode), .stk_valid(stk_valid), .stk_ready(stk_ready),
    .stk_overflow(stk_overflow), .busy(busy), .done(done), .err(err),
    .pc(pc), .issued(issued)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N+2:0] mk(input logic [2:0] op, input logic [N-1:0] a);
    return {op, a};
  endfunction

  // Write the whole model program into the DUT.
  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = prog[i];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Execute the loaded program; ovf_at is the 1-based handshake that raises
  // overflow (0 = never); abort_after >= 0 resets after that many issues.
  task automatic run_prog(input int ovf_at, input int pct, input int abort_after);
    int exp_n, exp_issued, exp_pc, k, cyc;
    bit halted, end_err;
    exp_n = 0;
    while (exp_n < DEPTH && prog[exp_n][N+2:N] != 3'b001) exp_n++;
    halted  = (exp_n < DEPTH);
    end_err = (ovf_at > 0) && (ovf_at <= exp_n);
    if (end_err) begin
      exp_issued = ovf_at;
      exp_pc     = (ovf_at > DEPTH - 1) ? DEPTH - 1 : ovf_at;
    end else begin
      exp_issued = exp_n;
      exp_pc     = halted ? exp_n : DEPTH - 1;
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err, 0);
    chk("start_busy", busy, 1);

    k = 0;
    cyc = 0;
    while (busy && cyc < 500) begin
      if (abort_after >= 0 && k == abort_after) begin
        stk_ready = 1'b0;
        stk_overflow = 1'b0;
        load_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_pc", pc, 0);
        chk("abort_issued", issued, 0);
        chk("abort_valid", stk_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (stk_valid) begin
        if (k < exp_n) begin
          chk("opcode", stk_opcode, prog[k][N+2:N]);
          chk("operand", stk_in, prog[k][N-1:0]);
          chk("run_pc", pc, k);
          chk("run_issued", issued, k);
        end else begin
          chk("extra_valid", stk_valid, 0);
        end
      end else begin
        chk("halt_pc", pc, exp_n);
      end
      stk_ready    = ($urandom_range(99) < pct);
      stk_overflow = (ovf_at > 0) && stk_ready && stk_valid && (k + 1 == ovf_at);
      load_en      = ($urandom_range(9) < 3);
      load_addr    = AW'($urandom_range(DEPTH - 1));
      load_data    = (N+3)'($urandom);
      if (stk_valid && stk_ready) k++;
      @(negedge clk);
      cyc++;
    end
    stk_ready = 1'b0;
    stk_overflow = 1'b0;
    load_en = 1'b0;
    if (cyc >= 500) chk("timeout", cyc, 0);
    chk("end_count", k, exp_issued);
    chk("end_issued", issued, exp_issued);
    chk("end_pc", pc, exp_pc);
    chk("end_done", done, end_err ? 0 : 1);
    chk("end_err", err, end_err ? 1 : 0);
    chk("end_valid", stk_valid, 0);
    chk("end_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; stk_ready = 1'b0; stk_overflow = 1'b0;
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_issued", issued, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", stk_valid, 0);
    chk("rst_opcode", stk_opcode, 0);
    chk("rst_in", stk_in, 0);
    @(negedge clk);
    rst = 1'b0;

    // push 1, push 2, add, pop, halt
    for (int i = 0; i < DEPTH; i++) prog[i] = mk(3'b001, 4'd0);
    prog[0] = mk(3'b110, 4'd1);
    prog[1] = mk(3'b110, 4'd2);
    prog[2] = mk(3'b100, 4'd0);
    prog[3] = mk(3'b111, 4'd0);
    load_prog();
    run_prog(0, 100, -1);
    run_prog(0, 40, -1);

    // five pushes, overflow on the fifth handshake
    for (int i = 0; i < DEPTH; i++) prog[i] = (i < 5) ? mk(3'b110, N'(i + 1)) : mk(3'b001, 4'd0);
    load_prog();
    run_prog(5, 100, -1);
    run_prog(0, 70, -1);

    // full program, no halt
    for (int i = 0; i < DEPTH; i++) prog[i] = mk(3'b110, 4'd3);
    load_prog();
    run_prog(0, 100, -1);
    run_prog(DEPTH, 60, -1);

    // reset mid-run, then rerun the retained program
    run_prog(0, 100, 2);
    run_prog(0, 100, -1);

    // random programs, nops included, occasional overflow
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        prog[i][N-1:0] = N'($urandom);
        if ($urandom_range(99) < 8) prog[i][N+2:N] = 3'b001;
        else prog[i][N+2:N] = ($urandom_range(1) == 1) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3) & 2'b10);
      end
      load_prog();
      run_prog(($urandom_range(2) == 0) ? $urandom_range(1, DEPTH) : 0,
               $urandom_range(30, 100), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
